// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of an external 4-bit combinational ALU.
// Incoming commands are buffered in a small FIFO. Each command is popped into
// a command register, executed for one cycle against the accumulator, and its
// result is then offered on a valid/ready output until the consumer takes it.
module alu_cmd_sequencer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DATA_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   // command input
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [DATA_W-1:0] in_operand,
   input  logic              in_chain,
   // external ALU
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic              alu_cin,
   output logic [2:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_cout,
   // result output
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_carry,
   output logic              out_zero,
   output logic              busy
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned EntW = 3 + DATA_W + 1;

   localparam logic [2:0] OpAdd   = 3'b000;
   localparam logic [2:0] OpLoad  = 3'b110;
   localparam logic [2:0] OpClear = 3'b111;

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e r_state;
   state_e w_state_nxt;

   logic [EntW-1:0]   r_mem [FIFO_DEPTH];
   logic [PtrW-1:0]   r_wr_ptr;
   logic [PtrW-1:0]   r_rd_ptr;
   logic [CntW-1:0]   r_count;

   logic [2:0]        r_cmd_op;
   logic [DATA_W-1:0] r_cmd_operand;
   logic              r_cmd_chain;

   logic [DATA_W-1:0] r_acc;
   logic              r_carry;
   logic              r_zero;

   logic              w_push;
   logic              w_pop;
   logic              w_not_empty;
   logic [EntW-1:0]   w_wr_entry;
   logic [EntW-1:0]   w_rd_entry;
   logic              w_alu_cin;
   logic [DATA_W-1:0] w_acc_nxt;
   logic              w_carry_nxt;

   // FIFO handshake and entry packing {op, operand, chain}
   assign in_ready    = (r_count != CntW'(FIFO_DEPTH));
   assign w_not_empty = (r_count != '0);
   assign w_push      = in_valid && in_ready;
   assign w_wr_entry  = {in_op, in_operand, in_chain};
   assign w_rd_entry  = r_mem[r_rd_ptr];

   // FIFO storage; contents need no reset because count gates every read
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_wr_entry;
      end
   end

   // FIFO pointers and occupancy; push and pop together leave count unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state, FIFO pop and carry-in selection
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_alu_cin   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_not_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = StExec;
            end
         end
         StExec: begin
            // chain only matters for ADD
            w_alu_cin   = (r_cmd_op == OpAdd) && r_cmd_chain && r_carry;
            w_state_nxt = StResp;
         end
         StResp: begin
            if (out_ready) begin
               if (w_not_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = StExec;
               end else begin
                  w_state_nxt = StIdle;
               end
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // command register, loaded on every pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cmd_op      <= '0;
         r_cmd_operand <= '0;
         r_cmd_chain   <= 1'b0;
      end else if (w_pop) begin
         {r_cmd_op, r_cmd_operand, r_cmd_chain} <= w_rd_entry;
      end
   end

   // accumulator/carry result of the current command; LOAD and CLEAR bypass the ALU
   always_comb begin
      w_acc_nxt   = alu_result;
      w_carry_nxt = 1'b0;
      unique case (r_cmd_op)
         OpAdd: begin
            w_acc_nxt   = alu_result;
            w_carry_nxt = alu_cout;
         end
         OpLoad:  w_acc_nxt = r_cmd_operand;
         OpClear: w_acc_nxt = '0;
         default: w_acc_nxt = alu_result;
      endcase
   end

   // accumulator and flags, captured at the end of EXEC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_zero  <= 1'b0;
      end else if (r_state == StExec) begin
         r_acc   <= w_acc_nxt;
         r_carry <= w_carry_nxt;
         r_zero  <= (w_acc_nxt == '0);
      end
   end

   assign alu_a     = r_acc;
   assign alu_b     = r_cmd_operand;
   assign alu_sel   = r_cmd_op;
   assign alu_cin   = w_alu_cin;

   assign out_valid = (r_state == StResp);
   assign out_data  = r_acc;
   assign out_carry = r_carry;
   assign out_zero  = r_zero;
   assign busy      = (r_state != StIdle) || w_not_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: models the external ALU, drives commands,
// and checks every delivered result against a queue of expected results.
module tb_alu_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op;
   logic [3:0] in_operand;
   logic       in_chain;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic       alu_cin;
   logic [2:0] alu_sel;
   logic [3:0] alu_result;
   logic       alu_cout;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       out_carry;
   logic       out_zero;
   logic       busy;

   alu_cmd_sequencer #(.FIFO_DEPTH(4), .DATA_W(4)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_operand (in_operand),
      .in_chain   (in_chain),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_cin    (alu_cin),
      .alu_sel    (alu_sel),
      .alu_result (alu_result),
      .alu_cout   (alu_cout),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_carry  (out_carry),
      .out_zero   (out_zero),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // external combinational ALU
   always_comb begin
      alu_result = 4'h0;
      alu_cout   = 1'b0;
      case (alu_sel)
         3'd0:    {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {4'h0, alu_cin};
         3'd1:    alu_result = alu_a & alu_b;
         3'd2:    alu_result = ~(alu_a | alu_b);
         3'd3:    alu_result = alu_a | alu_b;
         3'd4:    alu_result = ~alu_a;
         3'd5:    alu_result = alu_a ^ alu_b;
         default: alu_result = 4'h0;
      endcase
   end

   typedef struct {
      logic [2:0] op;
      logic [3:0] opnd;
      logic       ch;
      logic [3:0] ed;
      logic       ec;
      logic       ez;
   } vec_t;

   typedef struct {
      logic [3:0] d;
      logic       c;
      logic       z;
   } exp_t;

   exp_t       exp_q[$];
   int         total = 0;
   int         bad = 0;
   int         n_xfer = 0;
   logic [3:0] m_acc = 4'h0;
   logic       m_carry = 1'b0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // reference model of the accumulator/carry, advanced per accepted command
   task automatic model_step(input logic [2:0] op, input logic [3:0] opnd, input logic ch,
                             output logic [3:0] ed, output logic ec, output logic ez);
      logic [4:0] s;
      ec = 1'b0;
      case (op)
         3'd0: begin
            s  = {1'b0, m_acc} + {1'b0, opnd} + {4'h0, (ch & m_carry)};
            ed = s[3:0];
            ec = s[4];
         end
         3'd1:    ed = m_acc & opnd;
         3'd2:    ed = ~(m_acc | opnd);
         3'd3:    ed = m_acc | opnd;
         3'd4:    ed = ~m_acc;
         3'd5:    ed = m_acc ^ opnd;
         3'd6:    ed = opnd;
         default: ed = 4'h0;
      endcase
      ez      = (ed == 4'h0);
      m_acc   = ed;
      m_carry = ec;
   endtask

   // present one command until accepted; expected result queued on acceptance
   task automatic push_cmd(input logic [2:0] op, input logic [3:0] opnd, input logic ch,
                           input logic [3:0] ed, input logic ec, input logic ez);
      int waited = 0;
      in_valid   = 1'b1;
      in_op      = op;
      in_operand = opnd;
      in_chain   = ch;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL push_timeout: in_ready got 0 expected 1");
      end else begin
         exp_q.push_back('{d: ed, c: ec, z: ez});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic push_model(input logic [2:0] op, input logic [3:0] opnd, input logic ch);
      logic [3:0] ed;
      logic       ec;
      logic       ez;
      model_step(op, opnd, ch, ed, ec, ez);
      push_cmd(op, opnd, ch, ed, ec, ez);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("drain_empty", 8'(exp_q.size()), 8'd0);
      @(posedge clk);
      #1;
   endtask

   // scoreboard: compare every completed output handshake
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         n_xfer++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got data=%0h carry=%0b with nothing expected",
                     out_data, out_carry);
         end else begin
            e = exp_q.pop_front();
            check("out_data", {4'h0, out_data}, {4'h0, e.d});
            check("out_carry", {7'h0, out_carry}, {7'h0, e.c});
            check("out_zero", {7'h0, out_zero}, {7'h0, e.z});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   vec_t vecs[16];

   initial begin
      int         accepted;
      int         x0;
      logic [2:0] f_op[6];
      logic [3:0] f_opnd[6];
      logic       f_ch[6];
      logic [3:0] ed;
      logic       ec;
      logic       ez;

      vecs[0]  = '{3'd6, 4'h9, 1'b0, 4'h9, 1'b0, 1'b0}; // LOAD 9
      vecs[1]  = '{3'd0, 4'h8, 1'b0, 4'h1, 1'b1, 1'b0}; // ADD 8 -> overflow
      vecs[2]  = '{3'd0, 4'h0, 1'b1, 4'h2, 1'b0, 1'b0}; // ADD 0 chained
      vecs[3]  = '{3'd6, 4'hF, 1'b0, 4'hF, 1'b0, 1'b0}; // LOAD F
      vecs[4]  = '{3'd5, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1}; // XOR F
      vecs[5]  = '{3'd4, 4'h3, 1'b0, 4'hF, 1'b0, 1'b0}; // NOT
      vecs[6]  = '{3'd1, 4'h5, 1'b0, 4'h5, 1'b0, 1'b0}; // AND 5
      vecs[7]  = '{3'd3, 4'hA, 1'b0, 4'hF, 1'b0, 1'b0}; // OR A
      vecs[8]  = '{3'd2, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1}; // NOR 0
      vecs[9]  = '{3'd0, 4'hF, 1'b1, 4'hF, 1'b0, 1'b0}; // ADD F chained, carry clear
      vecs[10] = '{3'd0, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1}; // ADD 1 wraps to zero
      vecs[11] = '{3'd1, 4'h3, 1'b1, 4'h0, 1'b0, 1'b1}; // AND, chain ignored
      vecs[12] = '{3'd7, 4'h6, 1'b0, 4'h0, 1'b0, 1'b1}; // CLEAR
      vecs[13] = '{3'd6, 4'h7, 1'b0, 4'h7, 1'b0, 1'b0}; // LOAD 7
      vecs[14] = '{3'd0, 4'h9, 1'b0, 4'h0, 1'b1, 1'b1}; // ADD 9 -> 0 with carry
      vecs[15] = '{3'd0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0}; // ADD 0 chained

      f_op   = '{3'd6, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0};
      f_opnd = '{4'h1, 4'h2, 4'h3, 4'h5, 4'hF, 4'h0};
      f_ch   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      rst        = 1'b1;
      in_valid   = 1'b0;
      in_op      = 3'd0;
      in_operand = 4'h0;
      in_chain   = 1'b0;
      out_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {7'h0, out_valid}, 8'd0);
      check("rst_in_ready", {7'h0, in_ready}, 8'd1);
      check("rst_busy", {7'h0, busy}, 8'd0);
      check("rst_out_data", {4'h0, out_data}, 8'd0);
      check("rst_flags", {6'h0, out_carry, out_zero}, 8'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // table-driven sequence with the consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         model_step(vecs[i].op, vecs[i].opnd, vecs[i].ch, ed, ec, ez);
         push_cmd(vecs[i].op, vecs[i].opnd, vecs[i].ch, vecs[i].ed, vecs[i].ec, vecs[i].ez);
      end
      wait_drain();
      check("idle_busy", {7'h0, busy}, 8'd0);

      // result held stable for 10 cycles of backpressure, then exactly one transfer
      out_ready = 1'b0;
      model_step(3'd6, 4'h6, 1'b0, ed, ec, ez);
      push_cmd(3'd6, 4'h6, 1'b0, ed, ec, ez);
      for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
      check("hold_valid", {7'h0, out_valid}, 8'd1);
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         check("hold_valid_stable", {7'h0, out_valid}, 8'd1);
         check("hold_data", {3'h0, out_carry, out_data}, {3'h0, ec, ed});
         check("hold_zero", {7'h0, out_zero}, {7'h0, ez});
      end
      @(posedge clk);
      #1;
      x0 = n_xfer;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("hold_one_xfer", 8'(n_xfer - x0), 8'd1);
      check("hold_after_valid", {7'h0, out_valid}, 8'd0);

      // fill: one command reaches RESP and four wait in the FIFO before in_ready drops
      accepted = 0;
      for (int a = 0; a < 12 && accepted < 6; a++) begin
         in_valid   = 1'b1;
         in_op      = f_op[accepted];
         in_operand = f_opnd[accepted];
         in_chain   = f_ch[accepted];
         @(negedge clk);
         if (!in_ready) break;
         model_step(f_op[accepted], f_opnd[accepted], f_ch[accepted], ed, ec, ez);
         exp_q.push_back('{d: ed, c: ec, z: ez});
         accepted++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("fill_accepted", 8'(accepted), 8'd5);
      repeat (2) @(posedge clk);
      #1;
      check("fill_in_ready", {7'h0, in_ready}, 8'd0);
      check("fill_busy", {7'h0, busy}, 8'd1);
      out_ready = 1'b1;
      wait_drain();

      // latency: push into an idle, empty block
      out_ready = 1'b0;
      push_model(3'd6, 4'hC, 1'b0);
      @(negedge clk);
      check("lat_cycle1", {7'h0, out_valid}, 8'd0);
      @(negedge clk);
      check("lat_cycle2", {7'h0, out_valid}, 8'd0);
      @(negedge clk);
      check("lat_cycle3", {7'h0, out_valid}, 8'd1);
      out_ready = 1'b1;
      wait_drain();

      // reset while executing with two commands still queued
      out_ready = 1'b0;
      push_model(3'd6, 4'h5, 1'b0);
      push_model(3'd6, 4'h7, 1'b0);
      push_model(3'd0, 4'h1, 1'b0);
      push_model(3'd0, 4'h2, 1'b0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("pre_rst_exec_valid", {7'h0, out_valid}, 8'd0);
      check("pre_rst_busy", {7'h0, busy}, 8'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", {7'h0, out_valid}, 8'd0);
      check("mid_rst_acc", {4'h0, alu_a}, 8'd0);
      check("mid_rst_in_ready", {7'h0, in_ready}, 8'd1);
      check("mid_rst_busy", {7'h0, busy}, 8'd0);
      check("mid_rst_flags", {6'h0, out_carry, out_zero}, 8'd0);
      exp_q.delete();
      m_acc   = 4'h0;
      m_carry = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      x0 = n_xfer;
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_no_stale", 8'(n_xfer - x0), 8'd0);
      check("post_rst_busy", {7'h0, busy}, 8'd0);
      push_model(3'd0, 4'h3, 1'b1);
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
